// File: rtl/alu_cmd_issuer_if.sv
// Command handshake between the decode path and the ALU command issuer.
interface alu_cmd_issuer_if;
    logic       valid;
    logic       ready;
    logic       load;
    logic [2:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rd;
    logic [7:0] imm;

    modport master (
        output valid, load, op, ra, rb, rd, imm,
        input  ready
    );

    modport slave (
        input  valid, load, op, ra, rb, rd, imm,
        output ready
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues register-file commands to a combinational 8-bit ALU and captures
// its result and flags after a fixed settle window.
module alu_cmd_issuer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_issuer_if.slave     cmd,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [2:0]          alu_op,
    input  logic [7:0]          alu_y,
    input  logic                alu_zro,
    input  logic                alu_neg,
    input  logic                alu_so,
    input  logic                alu_co,
    input  logic                alu_ovr,
    output logic                done,
    output logic [7:0]          res_y,
    output logic [4:0]          flags,
    output logic [7:0]          op_count,
    input  logic [1:0]          dbg_addr,
    output logic [7:0]          dbg_data
);

    // Out-of-range settings are clamped to the legal 1..15 window.
    localparam int unsigned SETTLE =
        (SETTLE_CYCLES < 1)  ? 1  :
        (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] rd_q;
    logic [7:0] regs [4];
    logic       accept;

    assign cmd.ready = (state == IDLE) && !rst;
    assign accept    = cmd.valid && cmd.ready;
    assign dbg_data  = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_q     <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            done     <= 1'b0;
            res_y    <= '0;
            flags    <= '0;
            op_count <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && cmd.load) begin
                        regs[cmd.rd] <= cmd.imm;
                        res_y        <= cmd.imm;
                        done         <= 1'b1;
                    end else if (accept) begin
                        alu_a  <= regs[cmd.ra];
                        alu_b  <= regs[cmd.rb];
                        alu_op <= cmd.op;
                        rd_q   <= cmd.rd;
                        cnt    <= CNT_INIT;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Operands were latched at accept, so RD may alias RA/RB.
                        regs[rd_q] <= alu_y;
                        res_y      <= alu_y;
                        flags      <= {alu_zro, alu_neg, alu_so,
                                       alu_co, alu_ovr};
                        op_count   <= op_count + 8'd1;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: one instance with a 1-cycle settle
// window, one with a 4-cycle window, each driving a small ALU stub.
module tb_alu_cmd_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst4;
    int   vectors = 0;
    int   miscompares = 0;

    alu_cmd_issuer_if c1 ();
    alu_cmd_issuer_if c4 ();

    logic [7:0] a1, b1, y1, res1, opc1, dd1;
    logic [2:0] op1;
    logic [4:0] fl1;
    logic [8:0] s1;
    logic [1:0] da1;
    logic       done1, zro1, neg1, co1;

    logic [7:0] a4, b4, y4, res4, opc4, dd4;
    logic [2:0] op4;
    logic [4:0] fl4;
    logic [8:0] s4;
    logic [1:0] da4;
    logic       done4, zro4, neg4, co4;

    function automatic logic [8:0] alu_stub(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [2:0] op);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            3'b000:  return s;
            3'b100:  return {1'b0, a & b};
            default: return 9'd0;
        endcase
    endfunction

    assign s1   = alu_stub(a1, b1, op1);
    assign y1   = s1[7:0];
    assign co1  = s1[8];
    assign zro1 = (y1 == 8'd0);
    assign neg1 = y1[7];

    assign s4   = alu_stub(a4, b4, op4);
    assign y4   = s4[7:0];
    assign co4  = s4[8];
    assign zro4 = (y4 == 8'd0);
    assign neg4 = y4[7];

    alu_cmd_issuer #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst1), .cmd(c1.slave),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_y(y1),
        .alu_zro(zro1), .alu_neg(neg1), .alu_so(1'b0),
        .alu_co(co1), .alu_ovr(1'b0),
        .done(done1), .res_y(res1), .flags(fl1), .op_count(opc1),
        .dbg_addr(da1), .dbg_data(dd1)
    );

    alu_cmd_issuer #(.SETTLE_CYCLES(4)) u4 (
        .clk(clk), .rst(rst4), .cmd(c4.slave),
        .alu_a(a4), .alu_b(b4), .alu_op(op4), .alu_y(y4),
        .alu_zro(zro4), .alu_neg(neg4), .alu_so(1'b0),
        .alu_co(co4), .alu_ovr(1'b0),
        .done(done4), .res_y(res4), .flags(fl4), .op_count(opc4),
        .dbg_addr(da4), .dbg_data(dd4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue1(input logic ld, input logic [2:0] op,
                          input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic [7:0] imm);
        c1.load = ld; c1.op = op; c1.ra = ra;
        c1.rb = rb; c1.rd = rd; c1.imm = imm;
        c1.valid = 1'b1;
        step();
        c1.valid = 1'b0;
    endtask

    task automatic issue4(input logic ld, input logic [2:0] op,
                          input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic [7:0] imm);
        c4.load = ld; c4.op = op; c4.ra = ra;
        c4.rb = rb; c4.rd = rd; c4.imm = imm;
        c4.valid = 1'b1;
        step();
        c4.valid = 1'b0;
    endtask

    task automatic dbg1(input logic [1:0] addr, input logic [7:0] exp,
                        input string tag);
        da1 = addr;
        #1;
        chk(tag, dd1, exp);
    endtask

    task automatic dbg4(input logic [1:0] addr, input logic [7:0] exp,
                        input string tag);
        da4 = addr;
        #1;
        chk(tag, dd4, exp);
    endtask

    initial begin
        c1.valid = 0; c1.load = 0; c1.op = 0; c1.ra = 0;
        c1.rb = 0; c1.rd = 0; c1.imm = 0;
        c4.valid = 0; c4.load = 0; c4.op = 0; c4.ra = 0;
        c4.rb = 0; c4.rd = 0; c4.imm = 0;
        da1 = 0; da4 = 0;
        rst1 = 1; rst4 = 1;
        step();
        step();

        chk("rst_ready", c1.ready, 0);
        chk("rst_ready4", c4.ready, 0);
        chk("rst_done", done1, 0);
        chk("rst_res_y", res1, 0);
        chk("rst_flags", fl1, 0);
        chk("rst_op_count", opc1, 0);
        chk("rst_alu_a", a1, 0);
        rst1 = 0; rst4 = 0;
        #1;
        chk("ready_after_rst", c1.ready, 1);

        // back-to-back loads
        issue1(1, 3'b000, 0, 0, 0, 8'h35);
        chk("ld0_done", done1, 1);
        chk("ld0_res_y", res1, 8'h35);
        issue1(1, 3'b000, 0, 0, 1, 8'h0B);
        chk("ld1_done", done1, 1);
        chk("ld1_res_y", res1, 8'h0B);
        step();
        chk("ld_done_drop", done1, 0);
        dbg1(0, 8'h35, "dbg_r0");
        dbg1(1, 8'h0B, "dbg_r1");
        chk("ld_flags", fl1, 0);
        chk("ld_op_count", opc1, 0);

        // add, settle 1
        issue1(0, 3'b000, 0, 1, 2, 8'h00);
        chk("add_ready_busy", c1.ready, 0);
        chk("add_alu_a", a1, 8'h35);
        chk("add_alu_b", b1, 8'h0B);
        chk("add_alu_op", op1, 0);
        chk("add_no_early_done", done1, 0);
        step();
        chk("add_done", done1, 1);
        chk("add_ready", c1.ready, 1);
        chk("add_res_y", res1, 8'h40);
        chk("add_flags", fl1, 5'b00000);
        chk("add_op_count", opc1, 1);
        dbg1(2, 8'h40, "dbg_r2");

        // carry and zero
        issue1(1, 3'b000, 0, 0, 0, 8'hFF);
        issue1(1, 3'b000, 0, 0, 1, 8'h01);
        chk("ld_keeps_alu_a", a1, 8'h35);
        chk("ld_keeps_op_count", opc1, 1);
        chk("ld_keeps_flags", fl1, 0);
        issue1(0, 3'b000, 0, 1, 0, 8'h00);
        step();
        chk("carry_res_y", res1, 8'h00);
        chk("carry_flags", fl1, 5'b10010);
        chk("carry_op_count", opc1, 2);
        dbg1(0, 8'h00, "dbg_r0_carry");
        issue1(0, 3'b100, 0, 0, 3, 8'h00);
        chk("and_alu_a", a1, 8'h00);
        chk("and_alu_op", op1, 3'b100);
        step();
        chk("and_res_y", res1, 8'h00);
        chk("and_flags", fl1, 5'b10000);
        chk("and_op_count", opc1, 3);
        dbg1(3, 8'h00, "dbg_r3");
        step();
        chk("done_one_cycle", done1, 0);

        // settle 4, command held valid while busy
        issue4(1, 3'b000, 0, 0, 0, 8'h12);
        issue4(1, 3'b000, 0, 0, 1, 8'h34);
        c4.load = 0; c4.op = 3'b000; c4.ra = 0; c4.rb = 1; c4.rd = 2;
        c4.valid = 1;
        step();
        c4.op = 3'b100; c4.ra = 2; c4.rb = 1; c4.rd = 3;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk("s4_ready_low", c4.ready, 0);
            chk("s4_alu_a_hold", a4, 8'h12);
            chk("s4_alu_b_hold", b4, 8'h34);
            chk("s4_alu_op_hold", op4, 0);
            chk("s4_no_done", done4, 0);
        end
        step();
        chk("s4_done", done4, 1);
        chk("s4_ready_on_done", c4.ready, 1);
        chk("s4_res_y", res4, 8'h46);
        chk("s4_op_count", opc4, 1);
        step();
        c4.valid = 0;
        chk("s4_2nd_done_drop", done4, 0);
        chk("s4_2nd_accepted", c4.ready, 0);
        chk("s4_2nd_alu_a", a4, 8'h46);
        chk("s4_2nd_alu_b", b4, 8'h34);
        chk("s4_2nd_alu_op", op4, 3'b100);
        repeat (4) step();
        chk("s4_2nd_done", done4, 1);
        chk("s4_2nd_res_y", res4, 8'h04);
        chk("s4_2nd_flags", fl4, 5'b00000);
        chk("s4_2nd_op_count", opc4, 2);
        dbg4(3, 8'h04, "dbg4_r3");

        // reset in the middle of DRIVE
        issue4(0, 3'b000, 0, 1, 0, 8'h00);
        step();
        chk("abort_no_done_pre", done4, 0);
        rst4 = 1;
        step();
        chk("abort_ready_in_rst", c4.ready, 0);
        chk("abort_done", done4, 0);
        chk("abort_op_count", opc4, 0);
        chk("abort_res_y", res4, 0);
        chk("abort_flags", fl4, 0);
        chk("abort_alu_a", a4, 0);
        rst4 = 0;
        step();
        chk("abort_ready_after", c4.ready, 1);
        chk("abort_no_done_after", done4, 0);
        for (int i = 0; i < 4; i++) begin
            dbg4(2'(i), 8'h00, "abort_reg_zero");
        end

        // op_count wrap after 256 ALU ops; loads do not count
        rst1 = 1;
        step();
        rst1 = 0;
        for (int i = 0; i < 256; i++) begin
            issue1(0, 3'b000, 0, 0, 1, 8'h00);
            step();
            if (i == 127) begin
                issue1(1, 3'b000, 0, 0, 2, 8'h5A);
                chk("wrap_load_no_count", opc1, 128);
            end
            if (i == 254) chk("wrap_op_count_255", opc1, 255);
        end
        chk("wrap_op_count_0", opc1, 0);
        chk("wrap_done", done1, 1);
        dbg1(2, 8'h5A, "wrap_dbg_r2");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the 8-bit ALU datapath interface.
- Accepts register-level commands over a valid/ready handshake and reads operands from an internal 4x8 register file.
- Drives the ALU's A/B/OP inputs, waits a configurable settle time, then captures Y and ZRO/NEG/SO/CO/OVR into the destination register and a flag register.
- Sits between the instruction decode path and the combinational ALU.

Parameters:
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  issuer can accept a command.
- CMD_LOAD  input  1  1 = load immediate; 0 = ALU operation.
- CMD_OP  input  3  ALU opcode, passed through unmodified.
- CMD_RA  input  2  source register for ALU A.
- CMD_RB  input  2  source register for ALU B.
- CMD_RD  input  2  destination register.
- CMD_IMM  input  8  immediate for loads.
- ALU_A  output  8  registered operand A to ALU.
- ALU_B  output  8  registered operand B to ALU.
- ALU_OP  output  3  registered opcode to ALU.
- ALU_Y  input  8  ALU result.
- ALU_ZRO, ALU_NEG, ALU_SO, ALU_CO, ALU_OVR  input  1 each  ALU flags.
- DONE  output  1  one-cycle completion pulse.
- RES_Y  output  8  last written value.
- FLAGS  output  5  {ZRO,NEG,SO,CO,OVR} from last ALU op.
- OP_COUNT  output  8  completed ALU ops; wraps.
- DBG_ADDR  input  2  register-file debug read address.
- DBG_DATA  output  8  reg[DBG_ADDR], combinational.

Behaviour:
- Reset (RST high at a rising edge):
  - Outputs: regs 0..3 = 0, ALU_A/ALU_B = 0, ALU_OP = 0, DONE = 0, RES_Y = 0, FLAGS = 0, OP_COUNT = 0.
  - State and counter: state = IDLE, settle counter = 0.
  - CMD_READY = 0 while RST is high.
- Handshake:
  - Accept occurs at an edge where CMD_VALID && CMD_READY.
  - CMD_READY = (state==IDLE) && !RST, with no combinational dependency on CMD_VALID.
  - Command fields are sampled only at the accept edge.
- State IDLE:
  - Accept with CMD_LOAD=1: reg[RD] <= IMM and RES_Y <= IMM at the accept edge; DONE = 1 the following cycle; FLAGS, OP_COUNT and ALU_* unchanged; state stays IDLE, so back-to-back loads run at one per cycle.
  - Accept with CMD_LOAD=0: ALU_A <= reg[RA], ALU_B <= reg[RB], ALU_OP <= OP, latch RD, counter <= SETTLE_CYCLES-1, state <= DRIVE.
- State DRIVE:
  - ALU_A/ALU_B/ALU_OP held stable.
  - While counter != 0: counter decrements.
  - When counter == 0, at that edge: reg[RD] <= ALU_Y, RES_Y <= ALU_Y, FLAGS <= {ZRO,NEG,SO,CO,OVR}, OP_COUNT <= OP_COUNT+1 (255 wraps to 0), DONE <= 1, state <= IDLE.
- Latency and throughput:
  - Accept at edge k → capture at edge k+SETTLE_CYCLES → DONE high in the following cycle, during which CMD_READY is also high.
  - ALU-op throughput: one per SETTLE_CYCLES+1 cycles.
- DONE is high for exactly one cycle per completed command; it is never asserted for an aborted command.
- ALU_A/ALU_B/ALU_OP retain their last values in IDLE; they change only on ALU-op accept or reset.
- Operand and register rules:
  - RA==RB is legal.
  - RD equal to a source register is legal; the write occurs after operands have been latched.
  - A subsequent command reads the updated value, since reg write precedes the next accept.
- Reset in DRIVE: command aborts, no register/FLAGS/OP_COUNT write, no DONE, full reset values apply.
- CMD_VALID while not ready: ignored; the sender must hold the command until accepted.
- DBG_DATA reflects the register write from the cycle after the write edge.

Test Plan:
- Bench ALU stub: Y=A+B for OP=000, Y=A&B for OP=100; ZRO = Y==0, NEG = Y[7], CO = carry out of the add; SO and OVR tied 0.
- Reset then loads: LOAD r0=0x35, LOAD r1=0x0B on consecutive cycles → DONE on both following cycles, DBG r0=0x35, r1=0x0B, FLAGS=0, OP_COUNT=0.
- Add with SETTLE_CYCLES=1: OP=000, RA=0, RB=1, RD=2 → ALU_A=0x35, ALU_B=0x0B; DONE 2 cycles after accept; r2=0x40, RES_Y=0x40, FLAGS=00000, OP_COUNT=1.
- Carry/zero: r0=0xFF, r1=0x01, OP=000, RD=0 → r0=0x00, FLAGS: ZRO=1, CO=1; then OP=100, RA=RB=0, RD=3 → r3=0x00, ZRO=1.
- SETTLE_CYCLES=4:
  - CMD_READY low for exactly 4 cycles after accept.
  - ALU inputs stable throughout.
  - CMD_VALID held during the busy window causes no extra accept; second command accepted on the DONE cycle.
- Reset mid-DRIVE (SETTLE_CYCLES=4, assert RST 2 cycles after accept) → no DONE, all regs 0, OP_COUNT=0, CMD_READY=1 the cycle after RST deasserts.
- OP_COUNT wrap: 256 ALU ops → OP_COUNT returns to 0x00; loads do not increment it.
